// File: rtl/clk_divider_prog_pkg.sv
`default_nettype none
// clk_divider_prog_pkg: shared constants and state encoding for the programmable clock divider.
// Revision 1.0
package clk_divider_prog_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int DIV_MIN       = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } div_state_t;

endpackage : clk_divider_prog_pkg
`default_nettype wire

// File: rtl/clk_divider_prog.sv
`default_nettype none
// clk_divider_prog: registered divide-by-N clock with rise/fall strobes; ratio latched per period.
// Revision 1.0
module clk_divider_prog
  import clk_divider_prog_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  output logic             pclk,
  output logic             rise,
  output logic             fall,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] C_DIV_MIN = WIDTH'(DIV_MIN);

  div_state_t       r_state, w_state;
  logic [WIDTH-1:0] r_cnt,   w_cnt;
  logic [WIDTH-1:0] r_nq,    w_nq;
  logic             r_pclk,  w_pclk;
  logic             r_rise,  w_rise;
  logic             r_fall,  w_fall;

  logic [WIDTH-1:0] w_div_eff;
  logic [WIDTH-1:0] w_high;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_last;
  logic             w_inc_high;

  assign w_div_eff  = (div < C_DIV_MIN) ? C_DIV_MIN : div;
  // High phase is the ceiling half, so odd ratios spend the extra cycle high.
  assign w_high     = r_nq - (r_nq >> 1);
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_last     = (r_cnt == (r_nq - 1'b1));
  assign w_inc_high = (w_cnt_inc < w_high);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_nq    = r_nq;
    w_pclk  = r_pclk;
    w_rise  = 1'b0;
    w_fall  = 1'b0;
    if (!en) begin
      w_state = ST_IDLE;
      w_cnt   = '0;
      w_pclk  = 1'b0;
      w_fall  = r_pclk;
    end else if ((r_state == ST_IDLE) || w_last) begin
      // Period boundary: the only place a new ratio is accepted.
      w_state = ST_RUN;
      w_cnt   = '0;
      w_nq    = w_div_eff;
      w_pclk  = 1'b1;
      w_rise  = 1'b1;
    end else begin
      w_cnt   = w_cnt_inc;
      w_pclk  = w_inc_high;
      w_fall  = r_pclk & ~w_inc_high;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_nq    <= C_DIV_MIN;
      r_pclk  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_nq    <= w_nq;
      r_pclk  <= w_pclk;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
    end
  end

  assign pclk = r_pclk;
  assign rise = r_rise;
  assign fall = r_fall;
  assign cnt  = r_cnt;

endmodule : clk_divider_prog
`default_nettype wire

// File: tb/tb_clk_divider_prog.sv
`default_nettype none
// tb_clk_divider_prog: directed and randomized checks against a period-level reference model.
// Revision 1.0
module tb_clk_divider_prog;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] div;
  logic         pclk, rise, fall;
  logic [W-1:0] cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: phase within current period and the ratio of that period.
  bit m_run  = 0;
  int m_ph   = 0;
  int m_n    = 2;
  bit m_p    = 0;
  bit m_rise = 0;
  bit m_fall = 0;

  clk_divider_prog #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .div  (div),
    .pclk (pclk),
    .rise (rise),
    .fall (fall),
    .cnt  (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit e, input int d);
    bit old_p;
    old_p = m_p;
    if (!r) begin
      m_run = 0; m_ph = 0; m_n = 2; m_p = 0; m_rise = 0; m_fall = 0;
    end else if (!e) begin
      m_run = 0; m_ph = 0; m_p = 0; m_rise = 0; m_fall = old_p;
    end else begin
      if (!m_run || m_ph == m_n - 1) begin
        m_run = 1;
        m_ph  = 0;
        m_n   = (d < 2) ? 2 : d;
      end else begin
        m_ph = m_ph + 1;
      end
      m_p    = (m_ph < m_n - m_n / 2);
      m_rise = m_p && !old_p;
      m_fall = old_p && !m_p;
    end
  endtask

  task automatic step(input bit r, input bit e, input int d);
    rst_n = r;
    en    = e;
    div   = W'(d);
    @(posedge clk);
    model(r, e, d);
    #1;
    chk("pclk", 32'(pclk), 32'(m_p));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("cnt",  32'(cnt),  32'(m_ph));
    chk("rise_and_fall", 32'(rise & fall), 32'd0);
  endtask

  task automatic run_until_phase(input int d, input int ph);
    int guard;
    guard = 0;
    while (!(m_run && m_ph == ph) && guard < 300) begin
      step(1, 1, d);
      guard++;
    end
    chk("phase_reached", 32'(m_ph), 32'(ph));
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    div   = 8'd2;

    // Reset held three cycles with en high: reset must win.
    for (int i = 0; i < 3; i++) step(0, 1, 2);

    // Divide by two, then by five.
    for (int i = 0; i < 6; i++) step(1, 1, 2);
    for (int i = 0; i < 15; i++) step(1, 1, 5);

    // Degenerate ratios clamp to two.
    for (int i = 0; i < 6; i++) step(1, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 1);

    // Ratio change mid-period only takes effect at the next boundary.
    run_until_phase(4, 3);
    run_until_phase(4, 1);
    for (int i = 0; i < 9; i++) step(1, 1, 3);

    // Enable drop while pclk is high, then restart.
    run_until_phase(4, 3);
    run_until_phase(4, 1);
    step(1, 0, 4);
    chk("en_drop_fall", 32'(fall), 32'd1);
    step(1, 1, 4);
    chk("en_restart_rise", 32'(rise), 32'd1);
    for (int i = 0; i < 5; i++) step(1, 1, 4);

    // Reset mid-period: no fall strobe, clean restart.
    run_until_phase(6, 5);
    run_until_phase(6, 2);
    step(0, 1, 6);
    chk("rst_no_fall", 32'(fall), 32'd0);
    step(1, 1, 6);
    chk("rst_restart_rise", 32'(rise), 32'd1);
    for (int i = 0; i < 8; i++) step(1, 1, 6);

    // One full period at the largest ratio.
    for (int i = 0; i < 260; i++) step(1, 1, 255);

    // Randomized traffic.
    begin
      int d;
      d = 3;
      for (int i = 0; i < 1500; i++) begin
        bit r, e;
        if ($urandom_range(0, 9) == 0) d = int'($urandom_range(0, 12));
        r = ($urandom_range(0, 99) != 0);
        e = ($urandom_range(0, 19) != 0);
        step(r, e, d);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_clk_divider_prog
`default_nettype wire

// File: doc/clk_divider_prog.md
CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the bit width of the divide-ratio input and internal counter.
REQ-002 The block SHALL have input clk, 1 bit: the single clock; every register is updated on its rising edge.
REQ-003 The block SHALL have input rst_n, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have input en, 1 bit: run enable.
REQ-005 The block SHALL have input div, WIDTH bits: requested divide ratio N (period of pclk in clk cycles).
REQ-006 The block SHALL have output pclk, 1 bit: registered divided clock.
REQ-007 The block SHALL have output rise, 1 bit: one-cycle pulse, high in the cycle pclk has just gone 0->1.
REQ-008 The block SHALL have output fall, 1 bit: one-cycle pulse, high in the cycle pclk has just gone 1->0.
REQ-009 The block SHALL have output cnt, WIDTH bits: current phase counter, 0..Nq-1.

Function
REQ-010 Effective ratio SHALL be clamp(div) = 2 when div < 2, else div; Nq is the latched effective ratio.
REQ-011 The high phase SHALL be H = Nq - floor(Nq/2) cycles; pclk SHALL be high exactly while cnt < H (ceil duty: N=3 -> 1,1,0; N=5 -> 1,1,1,0,0).
REQ-012 State SHALL be the running flag plus the cnt, Nq, pclk, rise and fall registers; all outputs SHALL come straight from registers.
REQ-013 IDLE (running=0) with en=1 SHALL set, next cycle: running=1, cnt=0, Nq=clamp(div), pclk=1, rise=1, fall=0.
REQ-014 RUN with en=1 and cnt==Nq-1 SHALL set: cnt=0, Nq=clamp(div), pclk=1, rise=1, fall=0.
REQ-015 RUN with en=1 and cnt<Nq-1 SHALL set: cnt=cnt+1, pclk=(cnt+1<H), rise=0, fall=pclk AND NOT(cnt+1<H).
REQ-016 div SHALL be sampled only at a period boundary (REQ-013/014); changes mid-period SHALL NOT alter the current period (glitch-free ratio change).
REQ-017 en=0 in any state SHALL set, next cycle: running=0, cnt=0, pclk=0, rise=0, fall=pclk (a fall pulse only if pclk was high).
REQ-018 Counter arithmetic SHALL be WIDTH bits unsigned with no overflow, since cnt never exceeds Nq-1 <= 2^WIDTH-2.
REQ-019 rise and fall SHALL never be high in the same cycle.

Reset
REQ-020 rst_n=0 at a rising clk edge SHALL set running=0, cnt=0, Nq=2, pclk=0, rise=0, fall=0, and SHALL override en.
REQ-021 Reset asserted mid-period SHALL abort the period with no fall pulse; the first cycle with rst_n=1 and en=1 behaves per REQ-013.

Structure
REQ-022 A shared package SHALL hold DIV_MIN=2 and the default WIDTH=8 constants.
REQ-023 The block SHALL be a single module with no sub-module; the clamp SHALL be combinational logic inside it.

Verification
REQ-024 rst_n low 3 cycles, en=1, div=2 -> pclk 1,0,1,0...; rise in cycles 0,2,4; fall in cycles 1,3.
REQ-025 div=5, en=1 -> pclk pattern 1,1,1,0,0 repeating; cnt 0..4; rise every 5 cycles; fall at cnt=3.
REQ-026 div=0 and div=1 -> identical to div=2 behaviour.
REQ-027 div=4 running, change div to 3 at cnt=1 -> current period completes as 1,1,0,0, then 1,1,0 from the next boundary.
REQ-028 en dropped at cnt=1 with div=4 (pclk high) -> next cycle pclk=0, fall=1, cnt=0; en re-raised -> rise one cycle later.
REQ-029 rst_n pulsed low at cnt=2 with div=6 -> pclk=0, cnt=0, no fall pulse; with en=1 the restart matches REQ-013.
